// File: rtl/coord_renderer.sv
// Coordinate-list sprite renderer: 2-stage hit-test and priority pipeline.
// Define COORD_SNAPSHOT_EN to hit-test against a per-frame shadow of the list.
module coord_renderer #(
    parameter int         N_ENTRIES = 4,
    parameter int         SIZE      = 16,
    parameter logic [6:0] BG_COLOR  = 7'h00
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              count,
    input  logic [N_ENTRIES*24-1:0] ram,
    input  logic [9:0]              hcount,
    input  logic [9:0]              vcount,
    input  logic                    video_on,
    input  logic                    frame_start,
    output logic [6:0]              rgb,
    output logic                    video_on_d,
    output logic                    overlap_flag
);

    logic [N_ENTRIES*24-1:0] list_ram;
    logic [2:0]              list_cnt;

`ifdef COORD_SNAPSHOT_EN
    logic [N_ENTRIES*24-1:0] shadow_ram;
    logic [2:0]              shadow_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_ram <= '0;
            shadow_cnt <= '0;
        end else if (frame_start) begin
            shadow_ram <= ram;
            shadow_cnt <= count;
        end
    end

    assign list_ram = shadow_ram;
    assign list_cnt = shadow_cnt;
`else
    assign list_ram = ram;
    assign list_cnt = count;
`endif

    logic [N_ENTRIES-1:0]   hit_next;
    logic [N_ENTRIES*7-1:0] col_next;
    logic [10:0]            hc;
    logic [10:0]            vc;

    assign hc = {1'b0, hcount};
    assign vc = {1'b0, vcount};

    // Bounds in 11 bits: 2*255 + SIZE never wraps.
    for (genvar i = 0; i < N_ENTRIES; i++) begin : g_hit
        logic [10:0] x0;
        logic [10:0] y0;
        logic        active;
        logic        in_box;

        assign x0 = {2'b00, list_ram[i*24+8 +: 8], 1'b0};
        assign y0 = {2'b00, list_ram[i*24+16 +: 8], 1'b0};
        assign active = (int'(list_cnt) > i) && list_ram[i*24+7];
        assign in_box = (hc >= x0) && (hc < x0 + 11'(SIZE))
                     && (vc >= y0) && (vc < y0 + 11'(SIZE));
        assign hit_next[i] = video_on && active && in_box;
        assign col_next[i*7 +: 7] = list_ram[i*24 +: 7];
    end

    logic                   multi_hit;
    assign multi_hit = |(hit_next & (hit_next - {{(N_ENTRIES-1){1'b0}}, 1'b1}));

    logic [N_ENTRIES-1:0]   hit_q;
    logic [N_ENTRIES*7-1:0] col_q;
    logic                   von_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q <= '0;
            col_q <= '0;
            von_q <= 1'b0;
        end else begin
            hit_q <= hit_next;
            col_q <= col_next;
            von_q <= video_on;
        end
    end

    logic [6:0] pix;

    // Descending scan so the lowest-index hit is assigned last and wins.
    always_comb begin
        pix = BG_COLOR;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (hit_q[i]) pix = col_q[i*7 +: 7];
        end
        if (!von_q) pix = 7'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb        <= 7'h00;
            video_on_d <= 1'b0;
        end else begin
            rgb        <= pix;
            video_on_d <= von_q;
        end
    end

    logic acc;

    // Hits registered on the frame_start edge belong to the new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc          <= 1'b0;
            overlap_flag <= 1'b0;
        end else if (frame_start) begin
            overlap_flag <= acc;
            acc          <= multi_hit;
        end else begin
            acc <= acc | multi_hit;
        end
    end

endmodule
